// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and encodings for the pipeline hazard/forwarding controller.
package pipe_hazard_ctrl_pkg;

    localparam int REG_AW = 5;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b01;

    localparam int BR_EX  = 1;
    localparam int BR_MEM = 2;

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic              regwrite;
        logic              memread;
    } stage_t;

    // x0 is hard-wired zero, so it is never a real producer.
    function automatic logic stage_writes(stage_t s, logic [REG_AW-1:0] r);
        return s.valid & s.regwrite & (s.rd == r) & (r != '0);
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_fwd_mux.sv
// One EX operand forwarding mux: picks MEM, then WB, then the register-file value.
module fwd_mux
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int RADDR = 5
) (
    input  logic [RADDR-1:0] rs_i,
    input  stage_t           mem_i,
    input  stage_t           wb_i,
    input  logic [XLEN-1:0]  rf_data_i,
    input  logic [XLEN-1:0]  mem_data_i,
    input  logic [XLEN-1:0]  wb_data_i,
    output logic [1:0]       sel_o,
    output logic [XLEN-1:0]  op_o
);

    logic unused_wb_ld;
    assign unused_wb_ld = wb_i.memread;

    // A load in MEM only has an address on the ALU bus, never its data.
    always_comb begin
        sel_o = FWD_RF;
        op_o  = rf_data_i;
        if (stage_writes(mem_i, rs_i) && !mem_i.memread) begin
            sel_o = FWD_MEM;
            op_o  = mem_data_i;
        end else if (stage_writes(wb_i, rs_i)) begin
            sel_o = FWD_WB;
            op_o  = wb_data_i;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard, flush and forwarding control for a 5-stage RV32I pipeline.
// Define FWD_EN to build forwarding muxes (only load-use then stalls).
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int RADDR    = 5,
    parameter int BR_STAGE = 2,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [RADDR-1:0] id_rs1,
    input  logic [RADDR-1:0] id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [RADDR-1:0] id_rd,
    input  logic             id_regwrite,
    input  logic             id_memread,
    input  logic             br_taken,
    input  logic [XLEN-1:0]  ex_rs1data,
    input  logic [XLEN-1:0]  ex_rs2data,
    input  logic [XLEN-1:0]  mem_alu_result,
    input  logic [XLEN-1:0]  wb_writedata,
    output logic             pc_stall,
    output logic             ifid_stall,
    output logic             idex_bubble,
    output logic             ifid_flush,
    output logic             exmem_flush,
    output logic [1:0]       fwd_a_sel,
    output logic [1:0]       fwd_b_sel,
    output logic [XLEN-1:0]  op_a,
    output logic [XLEN-1:0]  op_b,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    stage_t ex_q, mem_q, wb_q;
    stage_t ex_d, mem_d, wb_d;
    logic [RADDR-1:0] ex_rs1_q, ex_rs2_q;
    logic             ex_use1_q, ex_use2_q;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
    logic             dep_ex, haz, flush, stall;

    assign dep_ex = (id_use_rs1 & stage_writes(ex_q, id_rs1))
                  | (id_use_rs2 & stage_writes(ex_q, id_rs2));

`ifdef FWD_EN
    assign haz = id_valid & ex_q.memread & dep_ex;
`else
    logic dep_mem, dep_wb;
    assign dep_mem = (id_use_rs1 & stage_writes(mem_q, id_rs1))
                   | (id_use_rs2 & stage_writes(mem_q, id_rs2));
    assign dep_wb  = (id_use_rs1 & stage_writes(wb_q, id_rs1))
                   | (id_use_rs2 & stage_writes(wb_q, id_rs2));
    assign haz = id_valid & (dep_ex | dep_mem | dep_wb);
`endif

    // A taken branch kills the stalled instruction anyway, so flush wins.
    assign flush       = br_taken;
    assign stall       = haz & ~flush;
    assign pc_stall    = stall;
    assign ifid_stall  = stall;
    assign idex_bubble = stall | flush;
    assign ifid_flush  = flush;
    assign exmem_flush = flush & (BR_STAGE == BR_MEM);

    always_comb begin
        ex_d          = '{valid: id_valid & ~idex_bubble, rd: id_rd,
                          regwrite: id_regwrite, memread: id_memread};
        mem_d         = ex_q;
        mem_d.valid   = ex_q.valid & ~exmem_flush;
        wb_d          = mem_q;
        stall_cnt_d   = stall_cnt_q + {{(CNT_W-1){1'b0}}, stall};
        flush_cnt_d   = flush_cnt_q + {{(CNT_W-1){1'b0}}, br_taken};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q        <= '0;
            mem_q       <= '0;
            wb_q        <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            ex_q        <= ex_d;
            mem_q       <= mem_d;
            wb_q        <= wb_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        ex_rs1_q  <= id_rs1;
        ex_rs2_q  <= id_rs2;
        ex_use1_q <= id_use_rs1;
        ex_use2_q <= id_use_rs2;
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

`ifdef FWD_EN
    logic unused_bits;
    assign unused_bits = ^{ex_use1_q, ex_use2_q, mem_q.memread, wb_q.memread};

    fwd_mux #(.XLEN(XLEN), .RADDR(RADDR)) u_fwd_a (
        .rs_i       (ex_rs1_q),
        .mem_i      (mem_q),
        .wb_i       (wb_q),
        .rf_data_i  (ex_rs1data),
        .mem_data_i (mem_alu_result),
        .wb_data_i  (wb_writedata),
        .sel_o      (fwd_a_sel),
        .op_o       (op_a)
    );

    fwd_mux #(.XLEN(XLEN), .RADDR(RADDR)) u_fwd_b (
        .rs_i       (ex_rs2_q),
        .mem_i      (mem_q),
        .wb_i       (wb_q),
        .rf_data_i  (ex_rs2data),
        .mem_data_i (mem_alu_result),
        .wb_data_i  (wb_writedata),
        .sel_o      (fwd_b_sel),
        .op_o       (op_b)
    );
`else
    logic unused_bits;
    assign unused_bits = ^{ex_rs1_q, ex_rs2_q, ex_use1_q, ex_use2_q,
                           mem_q.memread, wb_q.memread,
                           mem_alu_result, wb_writedata};

    assign fwd_a_sel = FWD_RF;
    assign fwd_b_sel = FWD_RF;
    assign op_a      = ex_rs1data;
    assign op_b      = ex_rs2data;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with an in-flight instruction log model.
module tb_pipe_hazard_ctrl;

    typedef struct packed {
        logic       v;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic [4:0] rd;
        logic       rw;
        logic       mr;
    } instr_t;

`ifdef FWD_EN
    localparam int RAW_ALU = 0;
    localparam int RAW_LD  = 1;
`else
    localparam int RAW_ALU = 3;
    localparam int RAW_LD  = 3;
`endif

    localparam logic [31:0] RF_A = 32'hAAAA_0001;
    localparam logic [31:0] RF_B = 32'hBBBB_0002;
    localparam logic [31:0] MEMV = 32'h0000_0007;
    localparam logic [31:0] WBV  = 32'h0000_00D0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic id_valid, id_use_rs1, id_use_rs2, id_regwrite, id_memread, br_taken;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic [31:0] ex_rs1data, ex_rs2data, mem_alu_result, wb_writedata;
    logic pc_stall, ifid_stall, idex_bubble, ifid_flush, exmem_flush;
    logic [1:0] fwd_a_sel, fwd_b_sel;
    logic [31:0] op_a, op_b, stall_cnt, flush_cnt;
    logic pc_stall_1, ifid_stall_1, idex_bubble_1, ifid_flush_1, exmem_flush_1;
    logic [1:0] fwd_a_sel_1, fwd_b_sel_1;
    logic [31:0] op_a_1, op_b_1, stall_cnt_1, flush_cnt_1;

    int total = 0;
    int bad = 0;
    bit started = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.XLEN(32), .RADDR(5), .BR_STAGE(2), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
        .id_regwrite(id_regwrite), .id_memread(id_memread), .br_taken(br_taken),
        .ex_rs1data(ex_rs1data), .ex_rs2data(ex_rs2data), .mem_alu_result(mem_alu_result),
        .wb_writedata(wb_writedata), .pc_stall(pc_stall), .ifid_stall(ifid_stall),
        .idex_bubble(idex_bubble), .ifid_flush(ifid_flush), .exmem_flush(exmem_flush),
        .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .op_a(op_a), .op_b(op_b),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    pipe_hazard_ctrl #(.XLEN(32), .RADDR(5), .BR_STAGE(1), .CNT_W(32)) dut_ex (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
        .id_regwrite(id_regwrite), .id_memread(id_memread), .br_taken(br_taken),
        .ex_rs1data(ex_rs1data), .ex_rs2data(ex_rs2data), .mem_alu_result(mem_alu_result),
        .wb_writedata(wb_writedata), .pc_stall(pc_stall_1), .ifid_stall(ifid_stall_1),
        .idex_bubble(idex_bubble_1), .ifid_flush(ifid_flush_1), .exmem_flush(exmem_flush_1),
        .fwd_a_sel(fwd_a_sel_1), .fwd_b_sel(fwd_b_sel_1), .op_a(op_a_1), .op_b(op_b_1),
        .stall_cnt(stall_cnt_1), .flush_cnt(flush_cnt_1)
    );

    // ---------------- model: log of every instruction entering EX ----------------
    instr_t log_q [0:2047];
    int cyc = 0;
    int base = 0;
    int exp_sc = 0;
    int exp_fc = 0;
    instr_t e0, e1, e2;
    logic m_haz, m_stall, m_flush;
    logic [1:0] m_sel_a, m_sel_b;
    logic [31:0] m_op_a, m_op_b;

    function automatic logic wr(instr_t e, logic [4:0] r);
        return e.v && e.rw && (e.rd == r) && (r != 5'd0);
    endfunction

    function automatic logic [1:0] fsel(instr_t em, instr_t ew, logic [4:0] r);
`ifdef FWD_EN
        if (wr(em, r) && !em.mr) return 2'b10;
        if (wr(ew, r)) return 2'b01;
`endif
        return 2'b00;
    endfunction

    function automatic logic [31:0] fop(logic [1:0] s, logic [31:0] rf);
        if (s == 2'b10) return MEMV;
        if (s == 2'b01) return WBV;
        return rf;
    endfunction

    always_comb begin
        e0 = '0;
        e1 = '0;
        e2 = '0;
        if (cyc - 1 >= base && cyc >= 1) e0 = log_q[cyc-1];
        if (cyc - 2 >= base && cyc >= 2) e1 = log_q[cyc-2];
        if (cyc - 3 >= base && cyc >= 3) e2 = log_q[cyc-3];
`ifdef FWD_EN
        m_haz = id_valid && e0.mr &&
                ((id_use_rs1 && wr(e0, id_rs1)) || (id_use_rs2 && wr(e0, id_rs2)));
`else
        m_haz = id_valid &&
                ((id_use_rs1 && (wr(e0, id_rs1) || wr(e1, id_rs1) || wr(e2, id_rs1))) ||
                 (id_use_rs2 && (wr(e0, id_rs2) || wr(e1, id_rs2) || wr(e2, id_rs2))));
`endif
        m_flush = br_taken;
        m_stall = m_haz && !m_flush;
        m_sel_a = fsel(e1, e2, e0.rs1);
        m_sel_b = fsel(e1, e2, e0.rs2);
        m_op_a  = fop(m_sel_a, ex_rs1data);
        m_op_b  = fop(m_sel_b, ex_rs2data);
    end

    always @(posedge clk) begin
        if (rst) begin
            base   <= cyc + 1;
            exp_sc <= 0;
            exp_fc <= 0;
        end else begin
            exp_sc <= exp_sc + int'(m_stall);
            exp_fc <= exp_fc + int'(br_taken);
            // a branch resolving in MEM kills the instruction leaving EX
            if (br_taken && cyc >= 1) log_q[cyc-1].v <= 1'b0;
        end
        log_q[cyc] <= '{v: id_valid && !m_stall && !br_taken, rs1: id_rs1, rs2: id_rs2,
                        u1: id_use_rs1, u2: id_use_rs2, rd: id_rd, rw: id_regwrite,
                        mr: id_memread};
        cyc <= cyc + 1;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- per-cycle compare against the model ----------------
    always @(negedge clk) begin
        if (started && !rst) begin
            chk("pc_stall", 64'(pc_stall), 64'(m_stall));
            chk("ifid_stall", 64'(ifid_stall), 64'(m_stall));
            chk("idex_bubble", 64'(idex_bubble), 64'(m_stall | m_flush));
            chk("ifid_flush", 64'(ifid_flush), 64'(m_flush));
            chk("exmem_flush", 64'(exmem_flush), 64'(m_flush));
            chk("ex_exmem_flush", 64'(exmem_flush_1), 64'd0);
            chk("ex_ifid_flush", 64'(ifid_flush_1), 64'(m_flush));
            chk("stall_cnt", 64'(stall_cnt), 64'(exp_sc));
            chk("flush_cnt", 64'(flush_cnt), 64'(exp_fc));
            if (e0.v) begin
                chk("fwd_a_sel", 64'(fwd_a_sel), 64'(m_sel_a));
                chk("fwd_b_sel", 64'(fwd_b_sel), 64'(m_sel_b));
                chk("op_a", 64'(op_a), 64'(m_op_a));
                chk("op_b", 64'(op_b), 64'(m_op_b));
            end
        end
    end

    // ---------------- stimulus ----------------
    function automatic instr_t mk(logic [4:0] rs1, logic [4:0] rs2, logic u1, logic u2,
                                  logic [4:0] rd, logic rw, logic mr);
        return '{v: 1'b1, rs1: rs1, rs2: rs2, u1: u1, u2: u2, rd: rd, rw: rw, mr: mr};
    endfunction

    task automatic drive(input instr_t ins, input logic br);
        id_valid    = ins.v;
        id_rs1      = ins.rs1;
        id_rs2      = ins.rs2;
        id_use_rs1  = ins.u1;
        id_use_rs2  = ins.u2;
        id_rd       = ins.rd;
        id_regwrite = ins.rw;
        id_memread  = ins.mr;
        br_taken    = br;
    endtask

    // Present one instruction in ID, holding it while the model says stall.
    task automatic run_instr(input instr_t ins, input logic br);
        int n;
        logic stl;
        n = 0;
        do begin
            drive(ins, br);
            #1;
            stl = m_stall;
            @(posedge clk);
            #1;
            n++;
        end while (stl && n < 12);
        if (stl) begin
            total++;
            bad++;
            $display("FAIL hold_bound: stall still %0d after %0d cycles, required 0", stl, n);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 4; i++) run_instr('0, 1'b0);
    endtask

    initial begin
        ex_rs1data     = RF_A;
        ex_rs2data     = RF_B;
        mem_alu_result = MEMV;
        wb_writedata   = WBV;
        drive('0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        started = 1'b1;
        #1;
        chk("rst_pc_stall", 64'(pc_stall), 64'd0);
        chk("rst_ifid_stall", 64'(ifid_stall), 64'd0);
        chk("rst_idex_bubble", 64'(idex_bubble), 64'd0);
        chk("rst_ifid_flush", 64'(ifid_flush), 64'd0);
        chk("rst_exmem_flush", 64'(exmem_flush), 64'd0);
        chk("rst_fwd_a_sel", 64'(fwd_a_sel), 64'd0);
        chk("rst_fwd_b_sel", 64'(fwd_b_sel), 64'd0);
        chk("rst_stall_cnt", 64'(stall_cnt), 64'd0);
        chk("rst_flush_cnt", 64'(flush_cnt), 64'd0);
        @(posedge clk);
        #1;

        // add x5,x1,x2 ; sub x6,x5,x3
        run_instr(mk(5'd1, 5'd2, 1, 1, 5'd5, 1, 0), 1'b0);
        run_instr(mk(5'd5, 5'd3, 1, 1, 5'd6, 1, 0), 1'b0);
        drive('0, 1'b0);
        #1;
`ifdef FWD_EN
        chk("alu_fwd_a_sel", 64'(fwd_a_sel), 64'h2);
        chk("alu_op_a", 64'(op_a), 64'h7);
`else
        chk("alu_fwd_a_sel", 64'(fwd_a_sel), 64'h0);
        chk("alu_op_a", 64'(op_a), 64'(RF_A));
`endif
        chk("alu_stall_cnt", 64'(stall_cnt), 64'(RAW_ALU));
        drain();

        // lw x5,0(x1) ; add x6,x5,x5
        run_instr(mk(5'd1, 5'd0, 1, 0, 5'd5, 1, 1), 1'b0);
        run_instr(mk(5'd5, 5'd5, 1, 1, 5'd6, 1, 0), 1'b0);
        drive('0, 1'b0);
        #1;
`ifdef FWD_EN
        chk("ld_fwd_a_sel", 64'(fwd_a_sel), 64'h1);
        chk("ld_fwd_b_sel", 64'(fwd_b_sel), 64'h1);
        chk("ld_op_a", 64'(op_a), 64'hD0);
        chk("ld_op_b", 64'(op_b), 64'hD0);
`else
        chk("ld_fwd_a_sel", 64'(fwd_a_sel), 64'h0);
        chk("ld_fwd_b_sel", 64'(fwd_b_sel), 64'h0);
`endif
        chk("ld_stall_cnt", 64'(stall_cnt), 64'(RAW_ALU + RAW_LD));
        drain();

        // lone taken branch
        drive('0, 1'b1);
        #1;
        chk("br_ifid_flush", 64'(ifid_flush), 64'd1);
        chk("br_idex_bubble", 64'(idex_bubble), 64'd1);
        chk("br_exmem_flush", 64'(exmem_flush), 64'd1);
        chk("br_ex_exmem_flush", 64'(exmem_flush_1), 64'd0);
        @(posedge clk);
        #1;
        drive('0, 1'b0);
        #1;
        chk("br_flush_cnt", 64'(flush_cnt), 64'd1);
        drain();

        // taken branch coincident with load-use
        run_instr(mk(5'd1, 5'd0, 1, 0, 5'd5, 1, 1), 1'b0);
        drive(mk(5'd5, 5'd5, 1, 1, 5'd6, 1, 0), 1'b1);
        #1;
        chk("brld_pc_stall", 64'(pc_stall), 64'd0);
        chk("brld_ifid_flush", 64'(ifid_flush), 64'd1);
        chk("brld_idex_bubble", 64'(idex_bubble), 64'd1);
        @(posedge clk);
        #1;
        drive('0, 1'b0);
        #1;
        chk("brld_stall_cnt", 64'(stall_cnt), 64'(RAW_ALU + RAW_LD));
        chk("brld_flush_cnt", 64'(flush_cnt), 64'd2);
        drain();

        // add x0,x1,x2 ; add x3,x0,x0
        run_instr(mk(5'd1, 5'd2, 1, 1, 5'd0, 1, 0), 1'b0);
        run_instr(mk(5'd0, 5'd0, 1, 1, 5'd3, 1, 0), 1'b0);
        drive('0, 1'b0);
        #1;
        chk("x0_fwd_a_sel", 64'(fwd_a_sel), 64'd0);
        chk("x0_fwd_b_sel", 64'(fwd_b_sel), 64'd0);
        chk("x0_stall_cnt", 64'(stall_cnt), 64'(RAW_ALU + RAW_LD));
        drain();

        // reset while a load-use stall is active
        run_instr(mk(5'd1, 5'd0, 1, 0, 5'd5, 1, 1), 1'b0);
        drive(mk(5'd5, 5'd5, 1, 1, 5'd6, 1, 0), 1'b0);
        #1;
        chk("pre_rst_pc_stall", 64'(pc_stall), 64'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("post_rst_pc_stall", 64'(pc_stall), 64'd0);
        chk("post_rst_idex_bubble", 64'(idex_bubble), 64'd0);
        chk("post_rst_stall_cnt", 64'(stall_cnt), 64'd0);
        chk("post_rst_flush_cnt", 64'(flush_cnt), 64'd0);
        run_instr(mk(5'd5, 5'd5, 1, 1, 5'd6, 1, 0), 1'b0);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Hazard, forwarding and flush controller for the 5-stage RV32I pipeline (IF, ID, EX, MEM, WB). It keeps a shadow copy of the destination and control bits of the EX, MEM and WB stages. From that state it produces:
- PC and IF/ID stall enables;
- ID/EX bubble insertion;
- a flush for younger stages on a taken branch;
- forwarded EX operand values.

Branch resolution stage is parametrised (EX or MEM). Data forwarding is a compile-time option.

## Interface
Parameters:
- XLEN, 32, datapath width of forwarded operands
- RADDR, 5, register-address width
- BR_STAGE, 2, stage resolving branches: 1 = EX, 2 = MEM
- CNT_W, 32, width of performance counters

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- id_valid  in  1  instruction in ID is real (not a bubble)
- id_rs1, id_rs2  in  RADDR  ID source registers
- id_use_rs1, id_use_rs2  in  1  ID instruction reads rs1 / rs2
- id_rd  in  RADDR  ID destination register
- id_regwrite, id_memread  in  1  ID control bits
- br_taken  in  1  branch in stage BR_STAGE is taken (qualified by that stage's valid)
- ex_rs1data, ex_rs2data  in  XLEN  register-file operands held in ID/EX
- mem_alu_result  in  XLEN  ALU result held in EX/MEM
- wb_writedata  in  XLEN  write-back mux output
- pc_stall, ifid_stall  out  1  hold PC / IF-ID register
- idex_bubble  out  1  load ID/EX with zero control
- ifid_flush  out  1  load IF/ID with a NOP
- exmem_flush  out  1  zero EX/MEM control; always 0 when BR_STAGE=1
- fwd_a_sel, fwd_b_sel  out  2  00 = register file, 10 = MEM, 01 = WB
- op_a, op_b  out  XLEN  forwarded EX operands
- stall_cnt, flush_cnt  out  CNT_W  stall cycles / taken-branch flushes

## Operation
Shadow state:
- Each of EX, MEM and WB holds {valid, rd, regwrite, memread}.
- EX additionally holds {rs1, rs2, use_rs1, use_rs2}.
- "P writes r" means P.valid & P.regwrite & P.rd == r & r != 0.
- Register x0 never creates a hazard and is never forwarded.

Hazard detection (combinational, ID vs shadow). "dep(P)" means the ID instruction uses rs1 or rs2 and P writes that register.
- With FWD_EN: haz = id_valid & EX.memread & dep(EX). This is the load-use case: one bubble.
- Without FWD_EN: haz = id_valid & (dep(EX) | dep(MEM) | dep(WB)).

Outputs:
- flush = br_taken.
- ifid_flush = flush.
- exmem_flush = flush & (BR_STAGE == 2).
- stall = haz & ~flush. Flush has priority over stall.
- pc_stall = ifid_stall = stall.
- idex_bubble = stall | flush.

Forwarding (FWD_EN only), per operand:
- MEM writes EX.rs -> sel 10.
- Else WB writes EX.rs -> sel 01.
- Else sel 00.
- MEM takes priority over WB.
- A load in MEM is never a forwarding source; the load-use stall guarantees this case never arises.
- Without FWD_EN: sel is constantly 00 and op = ex_rsXdata.

Shadow update each clk:
- WB <= MEM.
- MEM <= EX, with valid cleared if exmem_flush.
- EX <= ID, with valid cleared if idex_bubble.

Counters:
- stall_cnt increments on each cycle with stall = 1.
- flush_cnt increments on each cycle with br_taken = 1.
- Both wrap modulo 2^CNT_W.

## Timing
- Every output except the counters is combinational from the inputs and the shadow registers, within the same cycle.
- Load-use with FWD_EN: exactly 1 stall cycle.
- Without FWD_EN: a dependency on the immediately preceding instruction costs 3 stall cycles.
- Taken-branch penalty: BR_STAGE+1 flushed instructions (2 for EX, 3 for MEM).
- Reset: all shadow valid = 0 and counters = 0. Consequently pc_stall, ifid_stall, idex_bubble, ifid_flush and exmem_flush are 0, and fwd_*_sel = 00, in the cycle after rst unless inputs demand otherwise.
- rst asserted mid-stall or mid-flush: shadow valid is cleared on that edge, the stall drops, and no counter increments on that edge.
- Simultaneous br_taken and haz: flush only; stall_cnt is not incremented.

## Configuration
FWD_EN, defined: forwarding muxes and sel logic are present, and only load-use hazards stall. Undefined: no forwarding logic, op_a/op_b pass through the register-file operands, and any RAW hazard against EX, MEM or WB stalls until the producer retires.

## Structure
- The shared package holds:
  - the fwd_sel encodings FWD_RF, FWD_MEM, FWD_WB;
  - the BR_EX/BR_MEM constants;
  - a typedef for the shadow stage record.
- One sub-module, fwd_mux, instantiated once per operand. It takes the EX source register and the MEM/WB shadow, and produces sel and the operand value.

## Test plan
- add x5,x1,x2; sub x6,x5,x3 (FWD_EN) -> no stall; fwd_a_sel = 10 in sub's EX cycle; op_a = mem_alu_result (e.g. 0x0000_0007).
- lw x5,0(x1); add x6,x5,x5 (FWD_EN) -> 1 cycle stall with idex_bubble = 1; then fwd_a_sel = fwd_b_sel = 01 and op = load data; stall_cnt = 1.
- Same add/sub pair without FWD_EN -> stall for 3 cycles; then sel = 00; stall_cnt = 3.
- br_taken = 1 with BR_STAGE=2 -> ifid_flush = idex_bubble = exmem_flush = 1 for 1 cycle; flush_cnt = 1. With BR_STAGE=1 -> exmem_flush = 0.
- br_taken coincident with a load-use hazard -> pc_stall = 0, flush asserted, stall_cnt unchanged.
- add x0,x1,x2; add x3,x0,x0 -> sel 00 and no stall; assert rst during a stall -> next cycle all shadow valid = 0 and stall = 0.
